conv_result_collector: RTL and testbench

//   Output-side partner of systolic_datapath: captures the result_k1 stream qualified by window_valid_out

---
 rtl/systolic_pkg.sv | 33 +++
 rtl/ofmap_buffer.sv | 39 +++
 rtl/conv_result_collector.sv | 109 ++++++++++
 tb/tb_conv_result_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic datapath, its controller and the result collector:
// collector state encoding and the result/output geometry derivations.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Worst-case accumulation of a 2x2 window plus bias fits in 2*dataSize+5 bits.
    function automatic int res_w(input int data_size);
        return 2 * data_size + 5;
    endfunction

    function automatic int out_dim(input int img_width);
        return img_width - 1;
    endfunction

    function automatic int num_out(input int img_width);
        return out_dim(img_width) * out_dim(img_width);
    endfunction

    function automatic int addr_w(input int img_width);
        int n;
        int w;
        n = num_out(img_width);
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ofmap_buffer.sv
// Output feature-map storage: one write port, one registered read port.
// Only the read register is reset; the array holds undefined data until written.
module ofmap_buffer #(
    parameter int RES_W   = 21,
    parameter int NUM_OUT = 4,
    parameter int ADDR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RES_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RES_W-1:0]  rd_data
);

    logic [RES_W-1:0] mem [NUM_OUT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last output read back as zero rather than aliasing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (int'(rd_addr) < NUM_OUT) begin
                rd_data <= mem[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/conv_result_collector.sv
// Captures one frame of datapath results into the ofmap buffer, flags completion and
// serves host/FSM reads while not capturing.
module conv_result_collector
    import systolic_pkg::*;
#(
    parameter int dataSize  = 8,
    parameter int IMG_WIDTH = 3,
    localparam int RES_W    = res_w(dataSize),
    localparam int NUM_OUT  = num_out(IMG_WIDTH),
    localparam int ADDR_W   = addr_w(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              window_valid,
    input  logic [RES_W-1:0]  result_in,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   out_count,
    output logic              overflow,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic              rd_valid,
    output state_t            state_dbg
);

    // Handshake: result_in is sampled on every rising edge where window_valid is high;
    // there is no backpressure. rd_en is a one-shot request answered one cycle later by
    // rd_valid with rd_data, and is ignored while busy.

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_OUT - 1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q;
    logic            overflow_q;
    logic            frame_done_q;
    logic            rd_valid_q;
    logic            wr_en;
    logic            last_wr;
    logic            rd_ok;

    // A start cycle always wins: any result arriving with it is dropped.
    assign wr_en   = (state_q == ST_CAPTURE) && window_valid && !start;
    assign last_wr = wr_en && (count_q == LAST_IDX);
    assign rd_ok   = rd_en && (state_q != ST_CAPTURE);

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_CAPTURE: if (last_wr) state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= last_wr;
            rd_valid_q   <= rd_ok;
            if (start) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    count_q <= count_q + 1'b1;
                end
                if (window_valid && (state_q != ST_CAPTURE)) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    ofmap_buffer #(
        .RES_W  (RES_W),
        .NUM_OUT(NUM_OUT),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(count_q[ADDR_W-1:0]),
        .wr_data(result_in),
        .rd_en  (rd_ok),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign busy       = (state_q == ST_CAPTURE);
    assign frame_done = frame_done_q;
    assign out_count  = count_q;
    assign overflow   = overflow_q;
    assign rd_valid   = rd_valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: default 3x3 image instance plus a 4x4 instance
// used where an out-of-range read address is expressible.
module tb_conv_result_collector;
    import systolic_pkg::*;

    localparam int RES_W = 21;

    logic clk;
    logic rst;

    // Instance A: IMG_WIDTH=3 -> NUM_OUT=4, ADDR_W=2
    logic             a_start, a_valid, a_rd_en;
    logic [RES_W-1:0] a_result;
    logic [1:0]       a_rd_addr;
    logic             a_busy, a_frame_done, a_overflow, a_rd_valid;
    logic [2:0]       a_count;
    logic [RES_W-1:0] a_rd_data;
    state_t           a_state;

    // Instance B: IMG_WIDTH=4 -> NUM_OUT=9, ADDR_W=4
    logic             b_start, b_valid, b_rd_en;
    logic [RES_W-1:0] b_result;
    logic [3:0]       b_rd_addr;
    logic             b_busy, b_frame_done, b_overflow, b_rd_valid;
    logic [4:0]       b_count;
    logic [RES_W-1:0] b_rd_data;
    state_t           b_state;

    int checks = 0;
    int errors = 0;
    logic [RES_W-1:0] exp_q[$];

    conv_result_collector #(.dataSize(8), .IMG_WIDTH(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .window_valid(a_valid), .result_in(a_result),
        .busy(a_busy), .frame_done(a_frame_done), .out_count(a_count), .overflow(a_overflow),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .state_dbg(a_state)
    );

    conv_result_collector #(.dataSize(8), .IMG_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .window_valid(b_valid), .result_in(b_result),
        .busy(b_busy), .frame_done(b_frame_done), .out_count(b_count), .overflow(b_overflow),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .state_dbg(b_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are checked at that point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic a_idle();
        a_start = 0; a_valid = 0; a_rd_en = 0; a_result = '0; a_rd_addr = '0;
    endtask

    task automatic a_start_frame();
        a_start = 1; tick(); a_start = 0;
    endtask

    task automatic a_write(input logic [RES_W-1:0] v);
        a_valid = 1; a_result = v; tick(); a_valid = 0;
    endtask

    // Reads each address in turn, checking against the scoreboard queue.
    task automatic a_read_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            a_rd_en = 1; a_rd_addr = 2'(i);
            tick();
            a_rd_en = 0;
            chk({tag, "_rd_valid"}, 32'(a_rd_valid), 32'd1);
            chk({tag, "_rd_data"}, 32'(a_rd_data), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        int gap;
        a_idle();
        b_start = 0; b_valid = 0; b_rd_en = 0; b_result = '0; b_rd_addr = '0;

        // 1 Reset with random inputs applied
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            a_start = 1'($urandom_range(0, 1)); a_valid = 1'($urandom_range(0, 1));
            a_result = RES_W'($urandom_range(0, 2000)); a_rd_en = 1'($urandom_range(0, 1));
            a_rd_addr = 2'($urandom_range(0, 3));
            tick();
        end
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_frame_done", 32'(a_frame_done), 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_overflow", 32'(a_overflow), 0);
        chk("rst_rd_data", 32'(a_rd_data), 0);
        chk("rst_rd_valid", 32'(a_rd_valid), 0);
        chk("rst_state", 32'(a_state), 32'(ST_IDLE));
        a_idle();
        rst = 1;
        tick(); tick();
        chk("idle_busy", 32'(a_busy), 0);
        chk("idle_count", 32'(a_count), 0);

        // 4a Overflow while IDLE
        a_write(21'd55);
        chk("ovf_idle", 32'(a_overflow), 1);
        chk("ovf_idle_count", 32'(a_count), 0);

        // 2 Full frame, back-to-back
        a_start_frame();
        chk("f1_busy", 32'(a_busy), 1);
        chk("f1_ovf_cleared", 32'(a_overflow), 0);
        chk("f1_count0", 32'(a_count), 0);
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_result = RES_W'(10 * (i + 1));
            exp_q.push_back(RES_W'(10 * (i + 1)));
            tick();
            chk("f1_count", 32'(a_count), 32'(i + 1));
            chk("f1_frame_done", 32'(a_frame_done), (i == 3) ? 32'd1 : 32'd0);
        end
        a_valid = 0;
        chk("f1_busy_done", 32'(a_busy), 0);
        chk("f1_state", 32'(a_state), 32'(ST_DONE));
        tick();
        chk("f1_done_pulse_end", 32'(a_frame_done), 0);
        chk("f1_rd_valid_pre", 32'(a_rd_valid), 0);
        a_read_check("f1", 4);
        tick();
        chk("f1_rd_valid_drop", 32'(a_rd_valid), 0);
        chk("f1_rd_data_hold", 32'(a_rd_data), 32'd40);

        // 3 Gapped stream
        a_start_frame();
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_no_done", 32'(a_frame_done), 0);
            end
            a_write(RES_W'(100 + 7 * i));
            exp_q.push_back(RES_W'(100 + 7 * i));
            chk("gap_frame_done", 32'(a_frame_done), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("gap_count", 32'(a_count), 4);
        a_read_check("gap", 4);

        // 4b Overflow after DONE leaves memory and count alone
        a_write(21'h1FFFFF);
        chk("ovf_done", 32'(a_overflow), 1);
        chk("ovf_done_count", 32'(a_count), 4);
        a_rd_en = 1; a_rd_addr = 2'd3; tick(); a_rd_en = 0;
        chk("ovf_mem_kept", 32'(a_rd_data), 32'd121);

        // 5 Abort/restart; result arriving with start is dropped, not flagged
        a_start = 1; a_valid = 1; a_result = 21'd77; tick(); a_idle();
        chk("ab_ovf_cleared", 32'(a_overflow), 0);
        chk("ab_start_drop", 32'(a_count), 0);
        a_write(21'd1);
        a_write(21'd2);
        chk("ab_partial", 32'(a_count), 2);
        a_start_frame();
        chk("ab_restart_count", 32'(a_count), 0);
        chk("ab_restart_done", 32'(a_frame_done), 0);
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_result = RES_W'(5 + i);
            exp_q.push_back(RES_W'(5 + i));
            tick();
            chk("ab_frame_done", 32'(a_frame_done), (i == 3) ? 32'd1 : 32'd0);
        end
        a_valid = 0;
        a_read_check("ab", 4);

        // 6 Read edges: read with start in DONE sees pre-start data
        a_start = 1; a_rd_en = 1; a_rd_addr = 2'd0; tick(); a_idle();
        chk("rs_rd_valid", 32'(a_rd_valid), 1);
        chk("rs_rd_data", 32'(a_rd_data), 5);
        chk("rs_busy", 32'(a_busy), 1);
        a_rd_en = 1; a_rd_addr = 2'd2; tick(); a_rd_en = 0;
        chk("cap_rd_ignored", 32'(a_rd_valid), 0);
        chk("cap_rd_hold", 32'(a_rd_data), 5);
        a_write(21'd300);
        a_write(21'd301);
        chk("mid_count", 32'(a_count), 2);
        #2 rst = 0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_count", 32'(a_count), 0);
        chk("mid_rst_rd_data", 32'(a_rd_data), 0);
        chk("mid_rst_state", 32'(a_state), 32'(ST_IDLE));
        tick();
        rst = 1;
        tick();
        chk("post_rst_count", 32'(a_count), 0);

        // Out-of-range read on the 9-output instance
        b_start = 1; tick(); b_start = 0;
        for (int i = 0; i < 9; i++) begin
            b_valid = 1; b_result = RES_W'(1000 + i);
            tick();
        end
        b_valid = 0;
        chk("b_frame_done", 32'(b_frame_done), 1);
        chk("b_count", 32'(b_count), 9);
        b_rd_en = 1; b_rd_addr = 4'd8; tick();
        chk("b_rd_last", 32'(b_rd_data), 1008);
        b_rd_addr = 4'd12; tick(); b_rd_en = 0;
        chk("b_oor_valid", 32'(b_rd_valid), 1);
        chk("b_oor_data", 32'(b_rd_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
